// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous-read sprite ROM among sprite renderers;
// returns ROM data to the granted requester with a tagged valid pulse after the ROM latency.
module sprite_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 4,
  parameter int ROM_LAT = 1
) (
  input  logic                      vga_clk,
  input  logic                      Reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         rom_address,
  input  logic [DATA_W-1:0]         rom_q,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [2:0]                rsp_id
);

  localparam logic [3:0] NREQ = 4'(NUM_REQ);

  logic [NUM_REQ-1:0] r_gnt;
  logic [ADDR_W-1:0]  r_romAddress;
  logic [2:0]         r_ptr;
  logic [2:0]         r_issueId;
  logic [ROM_LAT-1:0] r_tagValid;
  logic [2:0]         r_tagId [ROM_LAT];

  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_rot;
  logic               w_found;
  logic [3:0]         w_sum;
  logic [2:0]         w_win;
  logic [2:0]         w_nextPtr;
  logic [ADDR_W-1:0]  w_winAddr;

  // A requester whose grant is showing this cycle sits out, so it cannot be granted twice in a row
  assign w_elig = req & ~r_gnt;
  assign w_rot  = NUM_REQ'({w_elig, w_elig} >> r_ptr);

  always_comb begin
    w_found = 1'b0;
    w_sum   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, r_ptr} + 4'(k);
      end
    end
    w_win     = (w_sum >= NREQ) ? 3'(w_sum - NREQ) : w_sum[2:0];
    w_nextPtr = (w_win == 3'(NUM_REQ - 1)) ? 3'd0 : w_win + 3'd1;
    w_winAddr = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_win == 3'(k)) w_winAddr = req_addr[k*ADDR_W +: ADDR_W];
    end
  end

  // Tag stage 0 is loaded from the grant register so it lines up with rom_q ROM_LAT cycles after gnt
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      r_gnt        <= '0;
      r_romAddress <= '0;
      r_ptr        <= '0;
      r_issueId    <= '0;
      r_tagValid   <= '0;
      for (int s = 0; s < ROM_LAT; s++) r_tagId[s] <= '0;
    end else begin
      if (w_found) begin
        r_gnt        <= NUM_REQ'(1) << w_win;
        r_romAddress <= w_winAddr;
        r_ptr        <= w_nextPtr;
        r_issueId    <= w_win;
      end else begin
        r_gnt <= '0;
      end
      r_tagValid[0] <= |r_gnt;
      r_tagId[0]    <= r_issueId;
      for (int s = 1; s < ROM_LAT; s++) begin
        r_tagValid[s] <= r_tagValid[s-1];
        r_tagId[s]    <= r_tagId[s-1];
      end
    end
  end

  assign gnt         = r_gnt;
  assign rom_address = r_romAddress;
  assign rsp_data    = rom_q;
  assign rsp_id      = r_tagValid[ROM_LAT-1] ? r_tagId[ROM_LAT-1] : 3'd0;
  assign rsp_valid   = r_tagValid[ROM_LAT-1] ? (NUM_REQ'(1) << r_tagId[ROM_LAT-1]) : '0;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Self-checking bench for sprite_rom_arbiter: a ROM_LAT=1 and a ROM_LAT=2 instance share
// the same requesters and are compared every cycle against a queue-based reference model.
module tb_sprite_rom_arbiter;

  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 4;

  typedef struct {
    int            due;
    int            id;
    logic [AW-1:0] addr;
  } rsp_t;

  logic            vga_clk = 1'b0;
  logic            Reset;
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_addr;

  logic [N-1:0]  gnt1, gnt2, rspValid1, rspValid2;
  logic [AW-1:0] romAddr1, romAddr2;
  logic [DW-1:0] romQ1, romQ2a, romQ2, rspData1, rspData2;
  logic [2:0]    rspId1, rspId2;

  int            checks   = 0;
  int            failures = 0;
  int            cyc      = 0;
  int            mGntId   = -1;
  int            mPtr     = 0;
  logic [AW-1:0] mAddr    = '0;
  bit            mKnown   = 1'b0;
  rsp_t          pend1[$];
  rsp_t          pend2[$];

  always #5 vga_clk = ~vga_clk;

  sprite_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1)) u_lat1 (
    .vga_clk(vga_clk), .Reset(Reset), .req(req), .req_addr(req_addr),
    .gnt(gnt1), .rom_address(romAddr1), .rom_q(romQ1),
    .rsp_valid(rspValid1), .rsp_data(rspData1), .rsp_id(rspId1)
  );

  sprite_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(2)) u_lat2 (
    .vga_clk(vga_clk), .Reset(Reset), .req(req), .req_addr(req_addr),
    .gnt(gnt2), .rom_address(romAddr2), .rom_q(romQ2),
    .rsp_valid(rspValid2), .rsp_data(rspData2), .rsp_id(rspId2)
  );

  function automatic logic [DW-1:0] romWord(input logic [AW-1:0] a);
    return DW'(a ^ (a >> 4) ^ (a >> 7) ^ AW'(5));
  endfunction

  // Sprite ROMs with one and two cycles of read latency
  always @(posedge vga_clk) begin
    romQ1  <= romWord(romAddr1);
    romQ2a <= romWord(romAddr2);
    romQ2  <= romQ2a;
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h cycle=%0d", name, got, exp, cyc);
    end
  endtask

  // Reference: grant = first requester at or after the pointer that is requesting and not
  // currently granted; its response is due 1+latency cycles after the sampling edge
  task automatic modelStep();
    int w;
    w = -1;
    if (Reset) begin
      mKnown = 1'b1;
      mGntId = -1;
      mAddr  = '0;
      mPtr   = 0;
      pend1.delete();
      pend2.delete();
    end else begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (mPtr + k) % N;
        if (w < 0 && req[i] && mGntId != i) w = i;
      end
      if (w >= 0) begin
        mGntId = w;
        mAddr  = req_addr[w*AW +: AW];
        mPtr   = (w + 1) % N;
        pend1.push_back('{cyc + 2, w, mAddr});
        pend2.push_back('{cyc + 3, w, mAddr});
      end else begin
        mGntId = -1;
      end
    end
    cyc++;
    while (pend1.size() > 0 && pend1[0].due < cyc) void'(pend1.pop_front());
    while (pend2.size() > 0 && pend2[0].due < cyc) void'(pend2.pop_front());
  endtask

  task automatic runCycle();
    @(posedge vga_clk);
    modelStep();
    @(negedge vga_clk);
    #1;
  endtask

  // Requesters obey the contract: a pending request holds until granted, unless withdrawn
  task automatic applyStimulus(input int density);
    Reset = ($urandom_range(0, 299) == 0);
    for (int i = 0; i < N; i++) begin
      if (req[i] && mGntId != i) begin
        if ($urandom_range(0, 19) == 0) req[i] = 1'b0;
      end else if ($urandom_range(0, 99) < density) begin
        req[i] = 1'b1;
        req_addr[i*AW +: AW] = AW'($urandom);
      end else begin
        req[i] = 1'b0;
      end
    end
  endtask

  always @(negedge vga_clk) begin
    logic [N-1:0] eg;
    if (mKnown) begin
      eg = (mGntId >= 0) ? (N'(1) << mGntId) : '0;
      checkOutput("gnt_lat1", 32'(gnt1), 32'(eg));
      checkOutput("gnt_lat2", 32'(gnt2), 32'(eg));
      checkOutput("rom_address_lat1", 32'(romAddr1), 32'(mAddr));
      checkOutput("rom_address_lat2", 32'(romAddr2), 32'(mAddr));
      if (pend1.size() > 0 && pend1[0].due == cyc) begin
        checkOutput("rsp_valid_lat1", 32'(rspValid1), 32'(1) << pend1[0].id);
        checkOutput("rsp_id_lat1", 32'(rspId1), 32'(pend1[0].id));
        checkOutput("rsp_data_lat1", 32'(rspData1), 32'(romWord(pend1[0].addr)));
      end else begin
        checkOutput("rsp_valid_lat1", 32'(rspValid1), 32'h0);
        checkOutput("rsp_id_lat1", 32'(rspId1), 32'h0);
      end
      if (pend2.size() > 0 && pend2[0].due == cyc) begin
        checkOutput("rsp_valid_lat2", 32'(rspValid2), 32'(1) << pend2[0].id);
        checkOutput("rsp_id_lat2", 32'(rspId2), 32'(pend2[0].id));
        checkOutput("rsp_data_lat2", 32'(rspData2), 32'(romWord(pend2[0].addr)));
      end else begin
        checkOutput("rsp_valid_lat2", 32'(rspValid2), 32'h0);
        checkOutput("rsp_id_lat2", 32'(rspId2), 32'h0);
      end
    end
  end

  initial begin
    Reset    = 1'b1;
    req      = '0;
    req_addr = '0;
    repeat (2) runCycle();

    // Single requester: granted, masked, granted again two cycles after the first
    Reset = 1'b0;
    req   = 4'b0001;
    req_addr[0 +: AW] = 10'h155;
    runCycle();
    checkOutput("single_gnt", 32'(gnt1), 32'h1);
    checkOutput("single_addr", 32'(romAddr1), 32'h155);
    runCycle();
    checkOutput("single_masked_gnt", 32'(gnt1), 32'h0);
    checkOutput("single_rsp_valid", 32'(rspValid1), 32'h1);
    checkOutput("single_rsp_data", 32'(rspData1), 32'(romWord(10'h155)));
    runCycle();
    checkOutput("single_regrant", 32'(gnt1), 32'h1);
    checkOutput("single_rsp_valid_lat2", 32'(rspValid2), 32'h1);

    // All four requesting: strict rotation 0,1,2,3,0
    Reset = 1'b1;
    runCycle();
    Reset    = 1'b0;
    req      = 4'b1111;
    req_addr = {10'h040, 10'h030, 10'h020, 10'h010};
    for (int j = 0; j < 5; j++) begin
      runCycle();
      checkOutput("rr_gnt", 32'(gnt1), 32'(1) << (j % 4));
      if (j > 0) begin
        checkOutput("rr_rsp_id", 32'(rspId1), 32'((j - 1) % 4));
        checkOutput("rr_rsp_data", 32'(rspData1), 32'(romWord(AW'(16 * ((j - 1) % 4 + 1)))));
      end
    end

    // Reset in the cycle a grant to requester 2 shows: its response must never appear
    repeat (2) runCycle();
    checkOutput("pre_reset_gnt", 32'(gnt1), 32'h4);
    Reset = 1'b1;
    runCycle();
    checkOutput("reset_gnt", 32'(gnt1), 32'h0);
    checkOutput("reset_no_rsp", 32'(rspValid1), 32'h0);
    Reset = 1'b0;
    runCycle();
    checkOutput("post_reset_gnt", 32'(gnt1), 32'h1);
    checkOutput("post_reset_no_rsp_lat2", 32'(rspValid2), 32'h0);

    // Randomized traffic at light, medium and heavy load
    for (int n = 0; n < 3000; n++) begin
      case ((n / 500) % 3)
        0:       applyStimulus(15);
        1:       applyStimulus(50);
        default: applyStimulus(90);
      endcase
      runCycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
